mantissa_normalizer: RTL and testbench

Post-add normalization stage of the floating-point adder datapath. Consumes the 9-bit raw mantissa sum/difference (carry bit plus 8 mantissa bits, hidden one at bit 7) and the tentative result exponent from the mantissa add/subtract stage. Produces a normalized 8-bit mantissa and adjusted exponent, with zero, overflow and underflow flags. Works sequentially, one shift per clock, under a start/busy/done handshake, and feeds the result packer.

---
 rtl/mantissa_normalizer.sv | 103 ++++++++++
 tb/tb_mantissa_normalizer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mantissa_normalizer.sv
// mantissa_normalizer: sequential post-add mantissa normalization, one shift per clock
module mantissa_normalizer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] sm_in,
  input  logic [7:0] exp_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] mant_out,
  output logic [7:0] exp_out,
  output logic       zero,
  output logic       overflow,
  output logic       underflow
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t     state_q, state_d;
  logic [8:0] m_q, m_d;
  logic [7:0] e_q, e_d;
  logic [7:0] mant_q, mant_d;
  logic [7:0] exp_q, exp_d;
  logic       zero_q, zero_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  // State and result registers; a reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      mant_q  <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // Next state: accept in IDLE, resolve or shift once per SHIFT cycle, pulse done in DONE
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        m_d     = sm_in;
        e_d     = exp_in;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
      SHIFT: begin
        state_d = DONE;
        if (m_q[8] && e_q == 8'hFF) begin
          mant_d = 8'h00;
          exp_d  = 8'hFF;
          ovf_d  = 1'b1;
        end else if (m_q[8]) begin
          mant_d = m_q[8:1];
          exp_d  = e_q + 8'd1;
        end else if (m_q == 9'd0) begin
          mant_d = 8'h00;
          exp_d  = 8'h00;
          zero_d = 1'b1;
        end else if (m_q[7]) begin
          mant_d = m_q[7:0];
          exp_d  = e_q;
        end else if (e_q == 8'd0) begin
          mant_d = m_q[7:0];
          exp_d  = 8'h00;
          unf_d  = 1'b1;
        end else begin
          state_d = SHIFT;
          m_d     = {m_q[7:0], 1'b0};
          e_d     = e_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign mant_out  = mant_q;
  assign exp_out   = exp_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_mantissa_normalizer.sv
// tb_mantissa_normalizer: directed and randomized checks against an arithmetic reference model
module tb_mantissa_normalizer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] sm_in = '0;
  logic [7:0] exp_in = '0;
  logic       busy, done, zero, overflow, underflow;
  logic [7:0] mant_out, exp_out;
  int         total = 0;
  int         bad = 0;
  logic [7:0] prev_mant = '0;
  logic [7:0] prev_exp = '0;

  mantissa_normalizer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sm_in(sm_in), .exp_in(exp_in),
    .busy(busy), .done(done), .mant_out(mant_out), .exp_out(exp_out),
    .zero(zero), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: result follows from the position of the leading one and the exponent budget
  task automatic model(input logic [8:0] sm, input logic [7:0] e,
                       output logic [7:0] m, output logic [7:0] x,
                       output logic [2:0] fl, output int lat);
    int p, need, ev;
    ev = e;
    fl = 3'b000;
    lat = 0;
    if (sm >= 9'd256) begin
      if (ev == 255) begin m = 8'h00; x = 8'hFF; fl = 3'b010; end
      else begin m = 8'(sm / 2); x = 8'(ev + 1); end
    end else if (sm == 0) begin
      m = 8'h00; x = 8'h00; fl = 3'b100;
    end else begin
      p = 0;
      for (int i = 0; i < 8; i++) if (sm[i]) p = i;
      need = 7 - p;
      if (need <= ev) begin
        m = 8'(sm * (1 << need)); x = 8'(ev - need); lat = need;
      end else begin
        m = 8'(sm * (1 << ev)); x = 8'h00; fl = 3'b001; lat = ev;
      end
    end
  endtask

  task automatic go(input logic [8:0] sm, input logic [7:0] e, input bit glitch);
    logic [7:0] m, x;
    logic [2:0] fl;
    int lat, n, bc;
    model(sm, e, m, x, fl, lat);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    start = 1'b1; sm_in = sm; exp_in = e;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("flags_clear", {zero, overflow, underflow}, 0);
    chk("mant_hold", mant_out, prev_mant);
    chk("exp_hold", exp_out, prev_exp);
    if (glitch) begin start = 1'b1; sm_in = ~sm; exp_in = ~e; end
    n = 0; bc = 1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) bc++;
    end while (!done && n < 20);
    chk("done_seen", done, 1);
    chk("latency", n, lat + 1);
    chk("busy_cycles", bc, lat + 2);
    chk("mant", mant_out, m);
    chk("exp", exp_out, x);
    chk("flags", {zero, overflow, underflow}, fl);
    prev_mant = m; prev_exp = x;
  endtask

  initial begin
    logic [8:0] sm;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {mant_out, exp_out, zero, overflow, underflow}, 0);
    @(negedge clk); rst_n = 1'b1;
    go(9'h1A4, 8'h80, 0);
    go(9'h013, 8'h10, 0);
    go(9'h000, 8'h55, 0);
    go(9'h004, 8'h02, 0);
    go(9'h180, 8'hFF, 0);
    go(9'h001, 8'h07, 0);
    go(9'h001, 8'h00, 0);
    go(9'h080, 8'h00, 0);
    go(9'h1FF, 8'hFE, 0);
    go(9'h013, 8'h10, 1);
    go(9'h1A4, 8'h80, 1);
    // Asynchronous reset in the middle of a five-shift job
    @(negedge clk);
    start = 1'b1; sm_in = 9'h004; exp_in = 8'h10;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_outs", {done, mant_out, exp_out, zero, overflow, underflow}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    rst_n = 1'b1;
    prev_mant = '0; prev_exp = '0;
    go(9'h004, 8'h10, 0);
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 4))
        0: sm = 9'($urandom_range(256, 511));
        1: sm = 9'd0;
        2: sm = 9'($urandom_range(1, 15));
        default: sm = 9'($urandom_range(0, 511));
      endcase
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      go(sm, ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 6)) :
             ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
         $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
